// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory, decoder and redirect signals of the fetch stage
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_gnt, imem_rvalid, imem_rdata, inst_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with one outstanding imem request and an in-order instruction queue
// Optional FETCH_NOP_FILL_EN: an empty queue presents addi x0,x0,0 instead of zero on inst.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int AW = $clog2(QDEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(QDEPTH);
`ifdef FETCH_NOP_FILL_EN
    localparam logic [31:0] FILL = 32'h0000_0013;
`else
    localparam logic [31:0] FILL = 32'h0000_0000;
`endif
    typedef enum logic [1:0] {REQ, WAIT, FLUSH} state_t;
    state_t        state;
    logic [31:0]   pc;
    logic [31:0]   fpc;
    logic          req;
    logic [CW-1:0] count;
    logic [CW-1:0] ncount;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [31:0]   qinst [QDEPTH];
    logic [31:0]   qpc [QDEPTH];
    logic          valid;
    logic          fire;
    logic          push;
    logic          pop;
    logic          room;

    // handshake qualifiers and next queue occupancy (redirect empties the queue)
    always_comb begin
        fire   = req && bus.imem_gnt;
        push   = (state == WAIT) && bus.imem_rvalid && !bus.redirect_valid;
        pop    = valid && bus.inst_ready;
        ncount = bus.redirect_valid ? '0 : count + CW'(push) - CW'(pop);
        room   = ncount < DEPTH;
    end

    // queue storage: fetched word and its pc written at the tail
    always_ff @(posedge clk) begin
        if (push) begin
            qinst[tail] <= bus.imem_rdata;
            qpc[tail]   <= fpc;
        end
    end

    // fetch FSM, pc, queue pointers and the registered request for the next cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= REQ;
            pc    <= RESET_PC;
            fpc   <= RESET_PC;
            req   <= 1'b0;
            count <= '0;
            head  <= '0;
            tail  <= '0;
        end else begin
            count <= ncount;
            head  <= bus.redirect_valid ? '0 : head + AW'(pop);
            tail  <= bus.redirect_valid ? '0 : tail + AW'(push);
            if (bus.redirect_valid)
                pc <= {bus.redirect_pc[31:2], 2'b00};
            else if (fire)
                pc <= pc + 32'd4;
            if (fire)
                fpc <= pc;
            case (state)
                REQ: begin
                    state <= fire ? (bus.redirect_valid ? FLUSH : WAIT) : REQ;
                    req   <= !fire && room;
                end
                WAIT: begin
                    state <= bus.imem_rvalid ? REQ : (bus.redirect_valid ? FLUSH : WAIT);
                    req   <= bus.imem_rvalid && room;
                end
                FLUSH: begin
                    state <= bus.imem_rvalid ? REQ : FLUSH;
                    req   <= bus.imem_rvalid && room;
                end
                default: begin
                    state <= REQ;
                    req   <= 1'b0;
                end
            endcase
        end
    end

    assign valid          = count != '0;
    assign bus.imem_req   = req;
    assign bus.imem_addr  = pc;
    assign bus.inst_valid = valid;
    assign bus.inst       = valid ? qinst[head] : FILL;
    assign bus.inst_pc    = valid ? qpc[head] : 32'h0;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed test-plan steps plus randomized traffic against a transaction-level model
module tb_fetch_unit;
    localparam logic [31:0] RPC = 32'h0000_0100;
`ifdef FETCH_NOP_FILL_EN
    localparam logic [31:0] FILL = 32'h0000_0013;
`else
    localparam logic [31:0] FILL = 32'h0000_0000;
`endif
    logic clk = 1'b0;
    logic rst = 1'b1;
    int tests = 0;
    int fails = 0;
    fetch_unit_if bus();
    fetch_unit #(.RESET_PC(RPC), .QDEPTH(2)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    // model: next fetch pc, pending fetch (0 none, 1 live, 2 squashed), queue of {pc, word}
    logic [31:0] m_pc = RPC;
    logic [31:0] m_fpc = 32'h0;
    bit          m_req = 1'b0;
    int          m_out = 0;
    logic [63:0] m_q[$];
    // memory stub: one pending request, answers with a word derived from its address
    bit          pend = 1'b0;
    logic [31:0] pend_addr = 32'h0;
    bit          req_s;
    logic [31:0] addr_s;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        chk("imem_req", 32'(bus.imem_req), 32'(m_req));
        chk("imem_addr", bus.imem_addr, m_pc);
        chk("inst_valid", 32'(bus.inst_valid), 32'(m_q.size() != 0));
        chk("inst", bus.inst, m_q.size() != 0 ? m_q[0][31:0] : FILL);
        chk("inst_pc", bus.inst_pc, m_q.size() != 0 ? m_q[0][63:32] : 32'h0);
    endtask

    task automatic model_step(bit g, bit rv, logic [31:0] d, bit rdy, bit rd, logic [31:0] rpc);
        bit fire;
        fire = m_req && g;
        if (rst) begin
            m_pc = RPC;
            m_req = 1'b0;
            m_out = 0;
            m_q.delete();
            return;
        end
        if (m_q.size() != 0 && rdy)
            void'(m_q.pop_front());
        if (m_out != 0 && rv) begin
            if (m_out == 1 && !rd)
                m_q.push_back({m_fpc, d});
            m_out = 0;
        end
        if (rd) begin
            m_q.delete();
            m_pc = rpc & 32'hFFFF_FFFC;
            if (m_out == 1 || fire)
                m_out = 2;
        end else if (fire) begin
            m_out = 1;
            m_fpc = m_pc;
            m_pc = m_pc + 32'd4;
        end
        m_req = (m_out == 0) && (m_q.size() < 2);
    endtask

    task automatic cyc(bit g, bit rv, bit rdy, bit rd, logic [31:0] rpc);
        logic [31:0] d;
        @(negedge clk);
        req_s = bus.imem_req;
        addr_s = bus.imem_addr;
        d = pend ? (pend_addr ^ 32'h5EED_0F0F) : $urandom;
        bus.imem_gnt = g;
        bus.imem_rvalid = rv;
        bus.imem_rdata = d;
        bus.inst_ready = rdy;
        bus.redirect_valid = rd;
        bus.redirect_pc = rpc;
        @(posedge clk);
        model_step(g, rv, d, rdy, rd, rpc);
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (rv)
                pend = 1'b0;
            if (req_s && g) begin
                pend = 1'b1;
                pend_addr = addr_s;
            end
        end
        #1 check_all();
    endtask

    initial begin
        logic [31:0] rpc;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.inst_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 32'h0;
        cyc(0, 0, 0, 0, 32'h0);
        cyc(0, 0, 0, 0, 32'h0);
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h100);
        chk("rst_valid", 32'(bus.inst_valid), 32'h0);
        chk("rst_inst", bus.inst, FILL);
        chk("rst_inst_pc", bus.inst_pc, 32'h0);
        rst = 1'b0;
        cyc(1, 1, 1, 0, 32'h0);
        chk("stray_rvalid_valid", 32'(bus.inst_valid), 32'h0);
        chk("first_req", 32'(bus.imem_req), 32'h1);
        chk("first_addr", bus.imem_addr, 32'h100);
        repeat (4) cyc(1, pend, 1, 0, 32'h0);
        chk("stream_inst_pc", bus.inst_pc, 32'h104);
        chk("stream_addr", bus.imem_addr, 32'h108);
        rst = 1'b1;
        cyc(0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        repeat (7) cyc(1, pend, 0, 0, 32'h0);
        chk("full_req", 32'(bus.imem_req), 32'h0);
        chk("full_valid", 32'(bus.inst_valid), 32'h1);
        chk("full_head", bus.inst_pc, 32'h100);
        cyc(1, pend, 1, 0, 32'h0);
        chk("drain_head", bus.inst_pc, 32'h104);
        chk("resume_req", 32'(bus.imem_req), 32'h1);
        chk("resume_addr", bus.imem_addr, 32'h108);
        cyc(1, pend, 1, 1, 32'h203);
        chk("flush_valid", 32'(bus.inst_valid), 32'h0);
        chk("flush_inst", bus.inst, FILL);
        chk("flush_req", 32'(bus.imem_req), 32'h0);
        cyc(1, pend, 1, 0, 32'h0);
        chk("flush_drop_valid", 32'(bus.inst_valid), 32'h0);
        chk("target_req", 32'(bus.imem_req), 32'h1);
        chk("target_addr", bus.imem_addr, 32'h200);
        cyc(1, pend, 1, 0, 32'h0);
        cyc(1, pend, 1, 0, 32'h0);
        chk("target_inst_pc", bus.inst_pc, 32'h200);
        cyc(1, pend, 1, 0, 32'h0);
        cyc(1, pend, 1, 1, 32'h400);
        chk("wait_redir_valid", 32'(bus.inst_valid), 32'h0);
        chk("wait_redir_req", 32'(bus.imem_req), 32'h1);
        chk("wait_redir_addr", bus.imem_addr, 32'h400);
        cyc(1, pend, 1, 0, 32'h0);
        cyc(1, pend, 1, 0, 32'h0);
        chk("wait_redir_inst_pc", bus.inst_pc, 32'h400);
        cyc(0, pend, 1, 1, 32'hFFFF_FFFC);
        chk("wrap_addr_pre", bus.imem_addr, 32'hFFFF_FFFC);
        cyc(1, pend, 1, 0, 32'h0);
        chk("wrap_addr", bus.imem_addr, 32'h0);
        cyc(1, pend, 1, 0, 32'h0);
        chk("wrap_inst_pc", bus.inst_pc, 32'hFFFF_FFFC);
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            cyc($urandom_range(0, 3) != 0, pend && ($urandom_range(0, 2) != 0),
                $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0, rpc);
        end
        rst = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
